one_wire_master: RTL and testbench

//  Byte-level 1-wire bus master for the DS2401 and DS2433 open-drain pins.

---
 rtl/one_wire_master.sv | 144 ++++++++++++++
 tb/tb_one_wire_master.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/one_wire_master.sv
// Byte-level 1-wire master: reset/presence, write and read slots timed in hardware for two lines.
// Latency acceptance->rspValid inclusive: reset (T_RSTL+T_RSTH)*TICK_DIV+2, byte 8*T_SLOT*TICK_DIV+2, reserved 2.
// Backpressure: cmdReady only in IDLE; cmdValid while busy is ignored, nothing is queued.
module one_wire_master #(
  parameter int TICK_DIV = 29,
  parameter int T_RSTL   = 480,
  parameter int T_PDS    = 70,
  parameter int T_RSTH   = 480,
  parameter int T_LOW1   = 6,
  parameter int T_LOW0   = 60,
  parameter int T_SAMPLE = 15,
  parameter int T_SLOT   = 70
) (
  input  logic       clock29M,
  input  logic       nReset,
  input  logic       cmdValid,
  output logic       cmdReady,
  input  logic [1:0] cmdOp,
  input  logic       cmdBus,
  input  logic [7:0] cmdData,
  input  logic [1:0] busIn,
  output logic [1:0] busPullLow,
  output logic       busy,
  output logic       rspValid,
  output logic [7:0] rspData,
  output logic       rspPresence
);

  typedef enum logic [2:0] {IDLE, RST_LOW, RST_HIGH, SLOT, DONE} state_t;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW = 10;
  localparam logic [PW-1:0] PRE_END    = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] RSTL_END   = TW'(T_RSTL - 1);
  localparam logic [TW-1:0] RSTH_END   = TW'(T_RSTH - 1);
  localparam logic [TW-1:0] PDS_END    = TW'(T_PDS - 1);
  localparam logic [TW-1:0] SAMPLE_END = TW'(T_SAMPLE - 1);
  localparam logic [TW-1:0] SLOT_END   = TW'(T_SLOT - 1);
  localparam logic [TW-1:0] LOW0_LEN   = TW'(T_LOW0);
  localparam logic [TW-1:0] LOW1_LEN   = TW'(T_LOW1);
  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  state_t state, stateNext;
  logic [PW-1:0] preCnt;
  logic [TW-1:0] tickCnt;
  logic [2:0]    bitCnt;
  logic [1:0]    opReg;
  logic          busReg;
  logic [7:0]    dataReg;
  logic [7:0]    shiftReg;
  logic          accept;
  logic          tickEnd;
  logic          phaseEnd;
  logic          lineIn;
  logic          lowActive;
  logic [TW-1:0] lowLen;

  always_comb begin
    accept    = cmdValid && (state == IDLE);
    tickEnd   = (preCnt == PRE_END);
    lineIn    = busIn[busReg];
    // Only a write of a 0 bit holds the line long; reads transmit all ones.
    lowLen    = ((opReg == OP_WRITE) && !dataReg[bitCnt]) ? LOW0_LEN : LOW1_LEN;
    phaseEnd  = 1'b0;
    stateNext = state;
    case (state)
      IDLE: begin
        if (accept) begin
          case (cmdOp)
            OP_RESET:         stateNext = RST_LOW;
            OP_WRITE, OP_READ: stateNext = SLOT;
            default:          stateNext = DONE;
          endcase
        end
      end
      RST_LOW: begin
        phaseEnd = tickEnd && (tickCnt == RSTL_END);
        if (phaseEnd) stateNext = RST_HIGH;
      end
      RST_HIGH: begin
        phaseEnd = tickEnd && (tickCnt == RSTH_END);
        if (phaseEnd) stateNext = DONE;
      end
      SLOT: begin
        phaseEnd = tickEnd && (tickCnt == SLOT_END);
        if (phaseEnd && (bitCnt == 3'd7)) stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase

    lowActive  = (state == RST_LOW) || ((state == SLOT) && (tickCnt < lowLen));
    busPullLow = 2'b00;
    if (lowActive) busPullLow[busReg] = 1'b1;
    cmdReady = (state == IDLE);
    busy     = (state != IDLE);
    rspValid = (state == DONE);
  end

  always_ff @(posedge clock29M) begin
    if (!nReset) begin
      state       <= IDLE;
      preCnt      <= '0;
      tickCnt     <= '0;
      bitCnt      <= '0;
      opReg       <= '0;
      busReg      <= 1'b0;
      dataReg     <= '0;
      shiftReg    <= '0;
      rspData     <= '0;
      rspPresence <= 1'b0;
    end else begin
      state <= stateNext;
      // Prescaler and tick count restart on acceptance and at every phase boundary.
      if (accept) begin
        opReg   <= cmdOp;
        busReg  <= cmdBus;
        dataReg <= cmdData;
        preCnt  <= '0;
        tickCnt <= '0;
        bitCnt  <= '0;
      end else if (phaseEnd) begin
        preCnt  <= '0;
        tickCnt <= '0;
        if (state == SLOT) bitCnt <= bitCnt + 3'd1;
      end else if (tickEnd) begin
        preCnt  <= '0;
        tickCnt <= tickCnt + TW'(1);
      end else begin
        preCnt  <= preCnt + PW'(1);
      end

      if ((state == RST_HIGH) && tickEnd && (tickCnt == PDS_END))
        rspPresence <= ~lineIn;
      if ((state == SLOT) && tickEnd && (tickCnt == SAMPLE_END))
        shiftReg[bitCnt] <= lineIn;
      if ((state == SLOT) && phaseEnd && (bitCnt == 3'd7))
        rspData <= shiftReg;
    end
  end

endmodule

// File: tb/tb_one_wire_master.sv
// Directed bench for one_wire_master: a small open-drain device model on each line plus a vector table.
// Runs with a shortened tick divider so every timing figure scales by DIV instead of 29.
`timescale 1ns/1ps
module tb_one_wire_master;
  localparam int DIV      = 8;
  localparam int T_RSTL   = 480;
  localparam int T_RSTH   = 480;
  localparam int T_LOW1   = 6;
  localparam int T_LOW0   = 60;
  localparam int T_SLOT   = 70;
  localparam int LAT_RST  = (T_RSTL + T_RSTH) * DIV + 2;
  localparam int LAT_BYTE = 8 * T_SLOT * DIV + 2;

  logic       clk = 1'b0;
  logic       nReset = 1'b0;
  logic       cmdValid = 1'b0;
  logic       cmdReady;
  logic [1:0] cmdOp = 2'b00;
  logic       cmdBus = 1'b0;
  logic [7:0] cmdData = 8'h00;
  logic [1:0] busIn;
  logic [1:0] busPullLow;
  logic       busy, rspValid, rspPresence;
  logic [7:0] rspData;

  always #5 clk = ~clk;

  one_wire_master #(.TICK_DIV(DIV)) dut (
    .clock29M(clk), .nReset(nReset), .cmdValid(cmdValid), .cmdReady(cmdReady),
    .cmdOp(cmdOp), .cmdBus(cmdBus), .cmdData(cmdData), .busIn(busIn),
    .busPullLow(busPullLow), .busy(busy), .rspValid(rspValid),
    .rspData(rspData), .rspPresence(rspPresence)
  );

  // Device model: mode 1 answers a reset with presence (low 20..140 ticks after release),
  // mode 2 answers read slots with devByte, LSB first, holding 0 bits low for 30 ticks.
  int         devMode = 0;
  logic       devBus = 1'b0;
  logic [7:0] devByte = 8'h00;
  int         slotBase = 0;
  int         slotN = 0;
  int         sinceFall = 1000000;
  int         sinceRise = 1000000;
  logic       prevPl = 1'b0;
  logic       pl, devLow;
  int         bitIdx;

  assign pl     = busPullLow[devBus];
  assign bitIdx = slotN - slotBase - 1;
  assign devLow = ((devMode == 1) && !pl && (sinceRise >= 20 * DIV) && (sinceRise < 140 * DIV)) ||
                  ((devMode == 2) && (bitIdx >= 0) && (bitIdx < 8) && !devByte[bitIdx[2:0]] &&
                   (sinceFall < 30 * DIV));
  assign busIn[0] = !(busPullLow[0] || (devLow && (devBus == 1'b0)));
  assign busIn[1] = !(busPullLow[1] || (devLow && (devBus == 1'b1)));

  always @(posedge clk) begin
    prevPl <= pl;
    if (pl && !prevPl) begin
      sinceFall <= 1;
      slotN     <= slotN + 1;
    end else begin
      sinceFall <= sinceFall + 1;
    end
    if (!pl && prevPl) sinceRise <= 1;
    else               sinceRise <= sinceRise + 1;
  end

  int nCmp = 0;
  int nErr = 0;

  task automatic check(input string name, input int act, input int exp);
    nCmp++;
    if (act != exp) begin
      nErr++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Observation results for the command in flight; cycle 1 is the cycle after the acceptance edge.
  int lat;
  int lows[$];
  int starts[$];
  int wrong;

  task automatic observe(input logic bus, input int budget);
    logic prev;
    int   lowStart;
    lows.delete();
    starts.delete();
    wrong = 0;
    lat = -1;
    prev = 1'b0;
    lowStart = 0;
    for (int c = 1; c <= budget; c++) begin
      if (busPullLow[!bus]) wrong++;
      if (busPullLow[bus] && !prev) begin
        lowStart = c;
        starts.push_back(c);
      end
      if (!busPullLow[bus] && prev) lows.push_back(c - lowStart);
      prev = busPullLow[bus];
      if (rspValid) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat < 0) begin
      nCmp++;
      nErr++;
      $display("FAIL timeout: no rspValid within %0d cycles", budget);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic bus, input logic [7:0] data);
    check("cmdReady before issue", int'(cmdReady), 1);
    cmdValid = 1'b1;
    cmdOp    = op;
    cmdBus   = bus;
    cmdData  = data;
    @(posedge clk); #1;
    cmdValid = 1'b0;
  endtask

  typedef struct {
    string      tag;
    logic [1:0] op;
    logic       bus;
    logic [7:0] data;
    int         mode;
    logic [7:0] devByte;
    logic [7:0] expData;
    logic       expPres;
    int         expLat;
    int         expLows;
    logic [7:0] longMask;
  } vec_t;

  task automatic runVec(input vec_t v);
    devMode  = v.mode;
    devBus   = v.bus;
    devByte  = v.devByte;
    slotBase = slotN;
    issue(v.op, v.bus, v.data);
    observe(v.bus, 40000);
    // Inclusive count: acceptance cycle is 1, rspValid cycle is lat+1.
    check({v.tag, " latency"}, lat + 1, v.expLat);
    check({v.tag, " rspData"}, int'(rspData), int'(v.expData));
    check({v.tag, " rspPresence"}, int'(rspPresence), int'(v.expPres));
    check({v.tag, " busy at rspValid"}, int'(busy), 1);
    check({v.tag, " low pulses"}, lows.size(), v.expLows);
    check({v.tag, " other line pulled"}, wrong, 0);
    if ((v.expLows == 1) && (lows.size() == 1))
      check({v.tag, " reset low width"}, lows[0], T_RSTL * DIV);
    if ((v.expLows == 8) && (lows.size() == 8) && (starts.size() == 8)) begin
      check({v.tag, " first low cycle"}, starts[0], 1);
      for (int i = 0; i < 8; i++) begin
        check($sformatf("%s slot%0d low width", v.tag, i), lows[i],
              (v.longMask[i] ? T_LOW0 : T_LOW1) * DIV);
        if (i < 7) check($sformatf("%s slot%0d period", v.tag, i), starts[i+1] - starts[i], T_SLOT * DIV);
      end
    end
    @(posedge clk); #1;
    check({v.tag, " rspValid one cycle"}, int'(rspValid), 0);
    check({v.tag, " busy cleared"}, int'(busy), 0);
  endtask

  vec_t vecs[6];
  vec_t after;

  initial begin
    vecs[0] = '{"rst bus0 presence", 2'b00, 1'b0, 8'h00, 1, 8'h00, 8'h00, 1'b1, LAT_RST, 1, 8'h00};
    vecs[1] = '{"rst bus1 empty",    2'b00, 1'b1, 8'h00, 0, 8'h00, 8'h00, 1'b0, LAT_RST, 1, 8'h00};
    vecs[2] = '{"write A5 bus1",     2'b01, 1'b1, 8'hA5, 0, 8'h00, 8'hA5, 1'b0, LAT_BYTE, 8, 8'h5A};
    vecs[3] = '{"read 3C bus0",      2'b10, 1'b0, 8'hFF, 2, 8'h3C, 8'h3C, 1'b0, LAT_BYTE, 8, 8'h00};
    vecs[4] = '{"reserved op",       2'b11, 1'b0, 8'h00, 0, 8'h00, 8'h3C, 1'b0, 2,        0, 8'h00};
    vecs[5] = '{"rst bus1 presence", 2'b00, 1'b1, 8'h00, 1, 8'h00, 8'h3C, 1'b1, LAT_RST, 1, 8'h00};
    after   = '{"read 96 post-abort", 2'b10, 1'b0, 8'h00, 2, 8'h96, 8'h96, 1'b0, LAT_BYTE, 8, 8'h00};

    nReset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busPullLow", int'(busPullLow), 0);
    check("reset busy", int'(busy), 0);
    check("reset rspValid", int'(rspValid), 0);
    check("reset rspData", int'(rspData), 0);
    check("reset rspPresence", int'(rspPresence), 0);
    check("reset cmdReady", int'(cmdReady), 1);
    nReset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) runVec(vecs[i]);

    // Abort a write of 0x00 while slot 3 is holding the line low.
    devMode = 0;
    devBus  = 1'b0;
    issue(2'b01, 1'b0, 8'h00);
    repeat (3 * T_SLOT * DIV + 10 * DIV) @(posedge clk);
    #1;
    check("abort line low before reset", int'(busPullLow), 1);
    nReset = 1'b0;
    @(posedge clk); #1;
    check("abort busPullLow", int'(busPullLow), 0);
    check("abort busy", int'(busy), 0);
    check("abort cmdReady", int'(cmdReady), 1);
    check("abort rspData", int'(rspData), 0);
    nReset = 1'b1;
    begin
      int seen = 0;
      for (int c = 0; c < 2 * T_SLOT * DIV; c++) begin
        if (rspValid || (busPullLow != 2'b00)) seen++;
        @(posedge clk); #1;
      end
      check("abort no activity after reset", seen, 0);
    end
    runVec(after);

    // cmdValid held through a read with a different op/data; only taken after DONE.
    devMode  = 2;
    devBus   = 1'b0;
    devByte  = 8'h5A;
    slotBase = slotN;
    cmdValid = 1'b1;
    cmdOp    = 2'b10;
    cmdBus   = 1'b0;
    cmdData  = 8'hC3;
    @(posedge clk); #1;
    cmdOp   = 2'b01;
    cmdData = 8'h00;
    observe(1'b0, 40000);
    check("held read latency", lat + 1, LAT_BYTE);
    check("held read rspData", int'(rspData), 8'h5A);
    check("held read low pulses", lows.size(), 8);
    begin
      int bad = 0;
      foreach (lows[i]) if (lows[i] != T_LOW1 * DIV) bad++;
      check("held read short lows only", bad, 0);
    end
    @(posedge clk); #1;
    check("held idle cmdReady", int'(cmdReady), 1);
    check("held idle busy", int'(busy), 0);
    @(posedge clk); #1;
    check("held accepted after done", int'(busy), 1);
    cmdValid = 1'b0;
    observe(1'b0, 40000);
    check("held write latency", lat + 1, LAT_BYTE);
    check("held write rspData", int'(rspData), 8'h00);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
